// File: rtl/regfile_ctrl.sv
// regfile_ctrl: sequences WRITE_IMM / COPY / SWAP / CLEAR_ALL commands onto an external 8-entry register file.
// SWAP datapath is built only when REGFILE_CTRL_SWAP_EN is defined; otherwise SWAP completes with err=1.
module regfile_ctrl #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [2:0]   cmd_rd,
    input  logic [2:0]   cmd_rs,
    input  logic [W-1:0] cmd_imm,
    output logic         done,
    output logic         err,
    output logic [W-1:0] rf_data_in,
    output logic [2:0]   rf_writenum,
    output logic         rf_write,
    output logic [2:0]   rf_readnum,
    input  logic [W-1:0] rf_data_out
);

    localparam logic [1:0] OP_WIMM = 2'b00;
    localparam logic [1:0] OP_COPY = 2'b01;
    localparam logic [1:0] OP_SWAP = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WIMM,
        RD_A,
        RD_B,
        WR_A,
        WR_B,
        CLR,
        FIN
    } state_t;

    state_t       state;
    logic [2:0]   rd_q;
    logic [2:0]   rs_q;
    logic [2:0]   count;
    logic [W-1:0] imm_q;
    logic [W-1:0] tmp_a;
`ifdef REGFILE_CTRL_SWAP_EN
    logic         swap_q;
    logic [W-1:0] tmp_b;
`else
    logic         err_q;
`endif

    // Command fields are latched once at accept, so later input changes cannot disturb the sequence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            rd_q   <= '0;
            rs_q   <= '0;
            imm_q  <= '0;
            tmp_a  <= '0;
            count  <= '0;
`ifdef REGFILE_CTRL_SWAP_EN
            swap_q <= 1'b0;
            tmp_b  <= '0;
`else
            err_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        rd_q  <= cmd_rd;
                        rs_q  <= cmd_rs;
                        imm_q <= cmd_imm;
`ifdef REGFILE_CTRL_SWAP_EN
                        swap_q <= (cmd_op == OP_SWAP);
`else
                        err_q  <= (cmd_op == OP_SWAP);
`endif
                        case (cmd_op)
                            OP_WIMM: state <= WIMM;
                            OP_COPY: state <= RD_A;
`ifdef REGFILE_CTRL_SWAP_EN
                            OP_SWAP: state <= RD_A;
`else
                            OP_SWAP: state <= FIN;
`endif
                            default: begin
                                state <= CLR;
                                count <= '0;
                            end
                        endcase
                    end
                end
                WIMM: state <= FIN;
                RD_A: begin
                    tmp_a <= rf_data_out;
`ifdef REGFILE_CTRL_SWAP_EN
                    state <= swap_q ? RD_B : WR_A;
`else
                    state <= WR_A;
`endif
                end
`ifdef REGFILE_CTRL_SWAP_EN
                RD_B: begin
                    tmp_b <= rf_data_out;
                    state <= WR_A;
                end
                WR_A: state <= swap_q ? WR_B : FIN;
                WR_B: state <= FIN;
`else
                WR_A: state <= FIN;
`endif
                CLR: begin
                    if (count == 3'd7) begin
                        state <= FIN;
                    end else begin
                        count <= count + 3'd1;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Moore decode: every output is a function of the registered state and latched fields only.
    always_comb begin
        cmd_ready   = (state == IDLE);
        done        = (state == FIN);
`ifdef REGFILE_CTRL_SWAP_EN
        err         = 1'b0;
`else
        err         = (state == FIN) && err_q;
`endif
        rf_write    = 1'b0;
        rf_writenum = '0;
        rf_data_in  = '0;
        rf_readnum  = '0;
        case (state)
            WIMM: begin
                rf_write    = 1'b1;
                rf_writenum = rd_q;
                rf_data_in  = imm_q;
            end
            RD_A: rf_readnum = rs_q;
            WR_A: begin
                rf_write    = 1'b1;
                rf_writenum = rd_q;
                rf_data_in  = tmp_a;
            end
`ifdef REGFILE_CTRL_SWAP_EN
            RD_B: rf_readnum = rd_q;
            WR_B: begin
                rf_write    = 1'b1;
                rf_writenum = rs_q;
                rf_data_in  = tmp_b;
            end
`endif
            CLR: begin
                rf_write    = 1'b1;
                rf_writenum = count;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/regfile_ctrl.md
REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 The block SHALL have parameter: W, default 16, data width of the register file and of cmd_imm.
REQ-002 The block SHALL have port: clk  input  1  single clock; all state updates on posedge.
REQ-003 The block SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port: cmd_valid  input  1  command offered.
REQ-005 The block SHALL have port: cmd_ready  output  1  block can accept a command.
REQ-006 The block SHALL have port: cmd_op  input  2  operation: 00 WRITE_IMM, 01 COPY, 10 SWAP, 11 CLEAR_ALL.
REQ-007 The block SHALL have port: cmd_rd  input  3  destination register number.
REQ-008 The block SHALL have port: cmd_rs  input  3  source register number.
REQ-009 The block SHALL have port: cmd_imm  input  W  immediate data for WRITE_IMM.
REQ-010 The block SHALL have port: done  output  1  one-cycle pulse on command completion.
REQ-011 The block SHALL have port: err  output  1  qualifies done; 1 = command rejected.
REQ-012 The block SHALL have port: rf_data_in  output  W  regfile write data.
REQ-013 The block SHALL have port: rf_writenum  output  3  regfile write register number.
REQ-014 The block SHALL have port: rf_write  output  1  regfile write enable, sampled by the regfile on posedge clk.
REQ-015 The block SHALL have port: rf_readnum  output  3  regfile read register number.
REQ-016 The block SHALL have port: rf_data_out  input  W  regfile combinational read data.

Function
REQ-017 The command handshake SHALL complete on a posedge where cmd_valid=1 and cmd_ready=1; op, rd, rs and imm are latched at that edge.
REQ-018 cmd_ready SHALL be 1 only in IDLE, so exactly one command is in flight at a time.
REQ-019 The FSM SHALL use states IDLE, WIMM, RD_A, RD_B, WR_A, WR_B, CLR, FIN; all datapath outputs SHALL be Moore outputs decoded from the state.
REQ-020 WRITE_IMM SHALL follow IDLE->WIMM->FIN; in WIMM: rf_write=1, rf_writenum=rd, rf_data_in=imm.
REQ-021 COPY SHALL follow IDLE->RD_A->WR_A->FIN.
REQ-022 In RD_A: rf_readnum=rs, and tmp_a captures rf_data_out at the exit edge.
REQ-023 In WR_A: rf_write=1, rf_writenum=rd, rf_data_in=tmp_a.
REQ-024 SWAP SHALL follow IDLE->RD_A->RD_B->WR_A->WR_B->FIN.
REQ-025 In RD_B: rf_readnum=rd, and tmp_b captures rf_data_out.
REQ-026 In WR_B: rf_write=1, rf_writenum=rs, rf_data_in=tmp_b.
REQ-027 CLEAR_ALL SHALL stay in CLR for 8 cycles with a 3-bit counter from 0 to 7; each cycle: rf_write=1, rf_writenum=counter, rf_data_in=0; exit to FIN when counter=7.
REQ-028 FIN SHALL last one cycle with done=1, then return to IDLE; done SHALL be 0 in every other state.
REQ-029 rf_write SHALL be 0 in IDLE, RD_A, RD_B and FIN, and when idle rf_writenum, rf_data_in and rf_readnum SHALL be 0.
REQ-030 Latency from the accept edge to the done cycle SHALL be: WRITE_IMM 2, COPY 3, SWAP 5, CLEAR_ALL 9 cycles.
REQ-031 rs==rd SHALL execute the normal sequence; register contents SHALL be unchanged.
REQ-032 cmd_valid, and changes to command inputs, while not ready SHALL be ignored.

Reset
REQ-033 reset=1 SHALL immediately, without waiting for clk, force state=IDLE, tmp_a=tmp_b=0, counter=0, done=0 and err=0.
REQ-034 Reset SHALL drive rf_write=0 and all rf_* outputs to 0.
REQ-035 After reset deassertion, cmd_ready=1 in the first cycle.
REQ-036 Reset asserted mid-command SHALL abort the command: no further writes and no done pulse; writes already committed remain.

Configuration
REQ-037 With macro REGFILE_CTRL_SWAP_EN defined, SWAP SHALL execute per REQ-024 to REQ-026.
REQ-038 With REGFILE_CTRL_SWAP_EN undefined, SWAP SHALL be accepted and go IDLE->FIN with no regfile write and err=1 with done; the RD_B and WR_B logic SHALL be absent.
REQ-039 err SHALL be 0 on done for all other operations in both builds.

Verification
REQ-040 The bench SHALL cover: after reset, WRITE_IMM rd=3 imm=42 -> rf_write high exactly one cycle, R3=42, done 2 cycles after accept, err=0.
REQ-041 The bench SHALL cover: R3=42 then COPY rs=3 rd=1 -> R1=42, R3=42, done at cycle 3, rf_write high only in WR_A.
REQ-042 The bench SHALL cover: R1=69 and R2=420 then SWAP rs=1 rd=2 -> with macro: R1=420, R2=69, done at cycle 5; without macro: R1 and R2 unchanged, done with err=1.
REQ-043 The bench SHALL cover: CLEAR_ALL -> R0..R7 all 0 after 8 consecutive write cycles, done at cycle 9, cmd_ready=0 throughout.
REQ-044 The bench SHALL cover: reset pulsed asynchronously during the WR_A cycle of SWAP -> rf_write falls immediately, no done, cmd_ready=1 after release.
REQ-045 The bench SHALL cover: cmd_valid held high with changing fields while busy -> only the first command executes.
